// File: rtl/clusterv_mgmt_regs.sv
// rtl/clusterv_mgmt_regs.sv - ClusterV management CSR target: reset vector, sys page, cluster reset, mgmt-to-sys mailbox.
module clusterv_mgmt_regs #(
    parameter logic [31:0] DEFAULT_RESET_VECTOR = 32'h10000000,
    parameter logic [31:0] ID_VALUE             = 32'hC1057E00,
    parameter int          RST_PULSE_CYCLES     = 16,
    parameter int          MBOX_DEPTH           = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] t_adr,
    input  logic [31:0] t_dat_w,
    output logic [31:0] t_dat_r,
    input  logic        t_cyc,
    input  logic        t_stb,
    input  logic        t_we,
    input  logic [3:0]  t_sel,
    output logic        t_ack,
    output logic        t_err,
    output logic [31:0] resvec,
    output logic [7:0]  sysaddr_page,
    output logic        core_reset,
    output logic [31:0] mbox_dat,
    output logic        mbox_valid,
    input  logic        mbox_ready
);

    localparam int PW = $clog2(MBOX_DEPTH);

    localparam logic [2:0] REG_ID     = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_RESVEC = 3'd2;
    localparam logic [2:0] REG_PAGE   = 3'd3;
    localparam logic [2:0] REG_MDATA  = 3'd4;
    localparam logic [2:0] REG_MSTAT  = 3'd5;

    logic          accept;
    logic          wr;
    logic          rd;
    logic [2:0]    reg_sel;
    logic [31:0]   rdata;

    logic          core_hold;
    logic [7:0]    pulse_cnt;
    logic          pulse_start;

    logic [31:0]   mbox_mem [MBOX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    count;
    logic          overflow;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    wire unused_bits = &{1'b0, t_adr[31:5], t_adr[1:0]};

    assign t_err   = 1'b0;
    assign reg_sel = t_adr[4:2];
    assign accept  = t_cyc & t_stb & ~t_ack;
    assign wr      = accept & t_we;
    assign rd      = accept & ~t_we;

    // A pulse request is only honoured from an idle counter so it can never be stretched.
    assign pulse_start = wr && (reg_sel == REG_CTRL) && t_dat_w[1] && (pulse_cnt == 8'd0);

    // Full is judged on pre-edge state, so a same-cycle pop cannot make room for a push.
    assign full       = (count == 5'(MBOX_DEPTH));
    assign push_req   = wr && (reg_sel == REG_MDATA);
    assign push_ok    = push_req & ~full;
    assign mbox_valid = (count != 5'd0);
    assign pop        = mbox_valid & mbox_ready;
    assign mbox_dat   = mbox_mem[rd_ptr];

    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            REG_ID:     rdata = ID_VALUE;
            REG_CTRL:   rdata = {30'h0, (pulse_cnt != 8'd0), core_hold};
            REG_RESVEC: rdata = resvec;
            REG_PAGE:   rdata = {24'h0, sysaddr_page};
            REG_MSTAT:  rdata = {22'h0, overflow, full, 3'b000, count};
            default:    rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t_ack        <= 1'b0;
            t_dat_r      <= 32'h0;
            resvec       <= DEFAULT_RESET_VECTOR;
            sysaddr_page <= 8'h0;
            core_hold    <= 1'b1;
            pulse_cnt    <= 8'd0;
            core_reset   <= 1'b1;
        end else begin
            t_ack   <= accept;
            t_dat_r <= rd ? rdata : 32'h0;

            if (wr && reg_sel == REG_CTRL)
                core_hold <= t_dat_w[0];

            if (wr && reg_sel == REG_RESVEC) begin
                for (int b = 0; b < 4; b++)
                    if (t_sel[b])
                        resvec[8*b +: 8] <= t_dat_w[8*b +: 8];
            end

            if (wr && reg_sel == REG_PAGE && t_sel[0])
                sysaddr_page <= t_dat_w[7:0];

            if (pulse_start)
                pulse_cnt <= 8'(RST_PULSE_CYCLES);
            else if (pulse_cnt != 8'd0)
                pulse_cnt <= pulse_cnt - 8'd1;

            core_reset <= core_hold | (pulse_cnt != 8'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase

            if (push_req && full)
                overflow <= 1'b1;
            else if (wr && reg_sel == REG_MSTAT && t_dat_w[9])
                overflow <= 1'b0;
        end
    end

    // Storage needs no reset: entries are only visible once count says they were written.
    always_ff @(posedge clock) begin
        if (push_ok)
            mbox_mem[wr_ptr] <= t_dat_w;
    end

endmodule

// File: tb/tb_clusterv_mgmt_regs.sv
// tb/tb_clusterv_mgmt_regs.sv - directed self-checking bench for clusterv_mgmt_regs.
module tb_clusterv_mgmt_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] t_adr;
    logic [31:0] t_dat_w;
    logic [31:0] t_dat_r;
    logic        t_cyc;
    logic        t_stb;
    logic        t_we;
    logic [3:0]  t_sel;
    logic        t_ack;
    logic        t_err;
    logic [31:0] resvec;
    logic [7:0]  sysaddr_page;
    logic        core_reset;
    logic [31:0] mbox_dat;
    logic        mbox_valid;
    logic        mbox_ready;

    int checks = 0;
    int errors = 0;
    int run_len = 0;
    int last_run = 0;

    logic [31:0] w [6];
    logic [31:0] rdv;

    clusterv_mgmt_regs dut (
        .clock        (clock),
        .reset        (reset),
        .t_adr        (t_adr),
        .t_dat_w      (t_dat_w),
        .t_dat_r      (t_dat_r),
        .t_cyc        (t_cyc),
        .t_stb        (t_stb),
        .t_we         (t_we),
        .t_sel        (t_sel),
        .t_ack        (t_ack),
        .t_err        (t_err),
        .resvec       (resvec),
        .sysaddr_page (sysaddr_page),
        .core_reset   (core_reset),
        .mbox_dat     (mbox_dat),
        .mbox_valid   (mbox_valid),
        .mbox_ready   (mbox_ready)
    );

    always #5 clock = ~clock;

    // Length of each contiguous core_reset high run, in cycles.
    always @(negedge clock) begin
        if (core_reset) begin
            run_len <= run_len + 1;
        end else begin
            if (run_len != 0)
                last_run <= run_len;
            run_len <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ack cycle with the bus released.
    task automatic access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, output logic [31:0] rd_data);
        if (t_ack === 1'b1) begin
            @(negedge clock);
            chk("ack_single_cycle", 32'(t_ack), 32'h0);
        end
        t_adr   = adr;
        t_dat_w = dat;
        t_sel   = sel;
        t_we    = we;
        t_cyc   = 1'b1;
        t_stb   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("ack_after_accept", 32'(t_ack), 32'h1);
        chk("err_zero", 32'(t_err), 32'h0);
        rd_data = t_dat_r;
        t_cyc   = 1'b0;
        t_stb   = 1'b0;
        t_we    = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        access(adr, dat, sel, 1'b1, dummy);
    endtask

    task automatic wb_read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        access(adr, 32'h0, 4'hF, 1'b0, v);
        chk(tag, v, exp);
    endtask

    initial begin
        w[0] = 32'hA0000001; w[1] = 32'hB0000002; w[2] = 32'hC0000003;
        w[3] = 32'hD0000004; w[4] = 32'hE0000005; w[5] = 32'hF0000006;
        reset = 1'b1; t_adr = 32'h0; t_dat_w = 32'h0; t_cyc = 1'b0; t_stb = 1'b0;
        t_we = 1'b0; t_sel = 4'h0; mbox_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        chk("rst_ack", 32'(t_ack), 32'h0);
        chk("rst_dat_r", t_dat_r, 32'h0);
        chk("rst_resvec", resvec, 32'h10000000);
        chk("rst_page", 32'(sysaddr_page), 32'h0);
        chk("rst_core_reset", 32'(core_reset), 32'h1);
        chk("rst_mbox_valid", 32'(mbox_valid), 32'h0);

        wb_read_chk("rd_id", 32'h00, 32'hC1057E00);
        wb_read_chk("rd_resvec", 32'h08, 32'h10000000);
        wb_read_chk("rd_page", 32'h0C, 32'h0);
        wb_read_chk("rd_ctrl", 32'h04, 32'h1);
        wb_read_chk("rd_id_alias", 32'hFFFF_FFE0, 32'hC1057E00);
        @(negedge clock);
        chk("dat_r_idle_zero", t_dat_r, 32'h0);

        wb_write(32'h08, 32'hAABBCCDD, 4'b0101);
        chk("resvec_ack_cycle", resvec, 32'h10BB00DD);
        wb_read_chk("rd_resvec_sel", 32'h08, 32'h10BB00DD);
        wb_write(32'h0C, 32'h00001234, 4'b0001);
        wb_write(32'h0C, 32'h000000FF, 4'b1110);
        chk("page_out", 32'(sysaddr_page), 32'h34);
        wb_read_chk("rd_page_w", 32'h0C, 32'h34);
        wb_write(32'h1C, 32'hFFFFFFFF, 4'hF);
        wb_read_chk("rd_reserved", 32'h18, 32'h0);
        chk("resvec_untouched", resvec, 32'h10BB00DD);

        wb_write(32'h04, 32'h0, 4'hF);
        wb_write(32'h04, 32'h2, 4'hF);
        chk("pulse_ack_cycle_low", 32'(core_reset), 32'h0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            chk($sformatf("pulse_high_%0d", i), 32'(core_reset), 32'h1);
        end
        @(negedge clock);
        chk("pulse_end_low", 32'(core_reset), 32'h0);
        @(negedge clock);
        chk("pulse_len", 32'(last_run), 32'd16);

        wb_write(32'h04, 32'h2, 4'hF);
        repeat (3) @(negedge clock);
        wb_write(32'h04, 32'h2, 4'hF);
        wb_read_chk("rd_ctrl_pulse", 32'h04, 32'h2);
        for (int i = 0; i < 60 && core_reset; i++)
            @(negedge clock);
        chk("pulse2_ended", 32'(core_reset), 32'h0);
        @(negedge clock);
        chk("pulse2_len", 32'(last_run), 32'd16);
        wb_read_chk("rd_ctrl_idle", 32'h04, 32'h0);

        chk("mbox_empty", 32'(mbox_valid), 32'h0);
        wb_write(32'h10, w[0], 4'h0);
        chk("mbox_valid_ack", 32'(mbox_valid), 32'h1);
        chk("mbox_dat_ack", mbox_dat, w[0]);
        for (int i = 1; i < 5; i++)
            wb_write(32'h10, w[i], 4'hF);
        wb_read_chk("stat_full_ovf", 32'h14, 32'h304);
        mbox_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_dat_%0d", i), mbox_dat, w[i]);
            chk($sformatf("drain_valid_%0d", i), 32'(mbox_valid), 32'h1);
            @(negedge clock);
        end
        chk("drained_empty", 32'(mbox_valid), 32'h0);
        mbox_ready = 1'b0;
        wb_read_chk("stat_ovf_sticky", 32'h14, 32'h200);
        wb_write(32'h14, 32'h200, 4'hF);
        wb_read_chk("stat_ovf_clear", 32'h14, 32'h0);

        for (int i = 0; i < 4; i++)
            wb_write(32'h10, w[i], 4'hF);
        @(negedge clock);
        chk("ack_dropped", 32'(t_ack), 32'h0);
        mbox_ready = 1'b1;
        wb_write(32'h10, w[4], 4'hF);
        mbox_ready = 1'b0;
        wb_read_chk("stat_full_pop", 32'h14, 32'h203);
        mbox_ready = 1'b1;
        @(negedge clock);
        wb_write(32'h10, w[5], 4'hF);
        mbox_ready = 1'b0;
        wb_read_chk("stat_push_pop", 32'h14, 32'h202);
        chk("head_after_pp", mbox_dat, w[3]);
        mbox_ready = 1'b1;
        @(negedge clock);
        chk("head_pushed", mbox_dat, w[5]);
        @(negedge clock);
        chk("pp_empty", 32'(mbox_valid), 32'h0);
        mbox_ready = 1'b0;

        wb_write(32'h04, 32'h2, 4'hF);
        wb_write(32'h10, w[0], 4'hF);
        chk("pre_rst_valid", 32'(mbox_valid), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_ack", 32'(t_ack), 32'h0);
        chk("midrst_valid", 32'(mbox_valid), 32'h0);
        chk("midrst_core_reset", 32'(core_reset), 32'h1);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("postrst_core_reset", 32'(core_reset), 32'h1);
        wb_read_chk("postrst_ctrl", 32'h04, 32'h1);
        wb_read_chk("postrst_stat", 32'h14, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clusterv_mgmt_regs.md
# clusterv_mgmt_regs

Management-side control/status register target for the ClusterV SoC. It sits on the register branch of the management Wishbone interconnect, downstream of the management port decoder. It holds the cluster reset vector, the system-address page and the cluster reset controls. It also provides a small mgmt-to-sys mailbox FIFO that the system clock domain drains through a valid/ready port.

## Interface
Parameters:
- DEFAULT_RESET_VECTOR, 32'h10000000, reset value of RESVEC
- ID_VALUE, 32'hC1057E00, value returned by the ID register
- RST_PULSE_CYCLES, 16, length in cycles of a software-requested cluster reset pulse (1..255)
- MBOX_DEPTH, 4, mailbox FIFO depth (power of two, 2..16)

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- t_adr  in  32  Wishbone address; only t_adr[4:2] decoded, upper bits alias
- t_dat_w  in  32  write data
- t_dat_r  out  32  read data
- t_cyc  in  1  cycle valid
- t_stb  in  1  strobe
- t_we  in  1  write enable
- t_sel  in  4  byte selects
- t_ack  out  1  acknowledge
- t_err  out  1  error; tied 0
- resvec  out  32  cluster reset vector
- sysaddr_page  out  8  upper system-address page for bridged accesses
- core_reset  out  1  reset to cluster cores
- mbox_dat  out  32  mailbox head data
- mbox_valid  out  1  mailbox non-empty
- mbox_ready  in  1  consumer accepts head

## Operation
Register map (byte offset):
- 0x00 ID: read-only, returns ID_VALUE.
- 0x04 CTRL:
  - bit0 core_hold: RW, reset 1.
  - bit1 pulse: write 1 starts a reset pulse; reads 1 while the pulse is active. Other bits read 0.
- 0x08 RESVEC: RW; per-byte writes honour t_sel.
- 0x0C SYSADDR_PAGE: [7:0] RW, written when t_sel[0]=1.
- 0x10 MBOX_DATA: write pushes the full t_dat_w (t_sel ignored); reads return 0.
- 0x14 MBOX_STATUS:
  - [4:0] count (RO).
  - bit8 full (RO).
  - bit9 overflow: sticky; write 1 clears it.
- 0x18, 0x1C: reserved. Reads return 0, writes are ignored, the access is still acked.

Wishbone behaviour:
- An access is accepted when t_cyc & t_stb & !t_ack.
- t_ack pulses high for exactly one cycle, in the cycle after acceptance.
- Holding t_stb yields one access every 2 cycles.
- t_dat_r is valid while t_ack=1 and is 0 otherwise.

Reset pulse:
- Writing CTRL with bit1=1 while the counter is 0 loads the counter with RST_PULSE_CYCLES. The counter then decrements every cycle until 0.
- Writing bit1=1 while the counter is non-zero is ignored; the pulse is not restarted.
- core_reset = reset | core_hold | (counter != 0), registered.

Mailbox:
- Circular FIFO of MBOX_DEPTH entries.
- Pop when mbox_valid & mbox_ready. mbox_dat is the head entry.
- Push when the FIFO is full: the data is dropped and overflow is set. A pop in the same cycle does not rescue the push; full is evaluated before that cycle's pop.
- Simultaneous push and pop when not full: count is unchanged and both take effect.
- Read and write pointers wrap modulo MBOX_DEPTH.

## Timing
- Reset values:
  - t_ack=0, t_dat_r=0
  - resvec=DEFAULT_RESET_VECTOR, sysaddr_page=0
  - core_hold=1, pulse counter=0, core_reset=1
  - mbox_valid=0, count=0, overflow=0, pointers=0
- Reset asserted mid-access: t_ack drops the next cycle and the access is lost. Reset mid-pulse clears the counter; core_hold returning to 1 keeps core_reset high.
- Register writes update on the same edge that raises t_ack. The new value is visible on outputs in the ack cycle.
- Reads sample register state at the acceptance edge, e.g. status count excludes a pop in the ack cycle.
- core_reset:
  - Rises 1 cycle after the ack of a pulse write.
  - Stays high RST_PULSE_CYCLES cycles; falls 1 cycle after the counter reaches 0 (if core_hold=0).
- Mailbox push:
  - mbox_valid rises in the ack cycle of the push; mbox_dat is valid then.
  - Push-to-valid latency is 1 cycle after acceptance.
- Mailbox pop: next entry or mbox_valid=0 appears on the following cycle.

## Test plan
- Reset then read 0x00, 0x08, 0x0C, 0x04 -> 0xC1057E00, 0x10000000, 0x0, 0x1; core_reset=1; every ack is a single-cycle pulse.
- Write RESVEC 0xAABBCCDD with t_sel=4'b0101, starting from 0x10000000 -> read 0x10BB00DD; resvec output matches in the ack cycle.
- Write CTRL=0 then CTRL=2 (RST_PULSE_CYCLES=16) -> core_reset low after the first write; high for exactly 16 cycles after the second. A repeat CTRL=2 at cycle 5 of the pulse does not extend it.
- Push 5 words with mbox_ready=0 (depth 4) -> status count=4, full=1, overflow=1. Drain -> words 1..4 in order, word 5 absent. Write 0x200 to 0x14 -> overflow=0.
- Push while full with mbox_ready=1 in the same cycle -> word dropped, overflow set, count 3. Push with count=2 and a simultaneous pop -> count stays 2.
- Assert reset during the ack cycle of a mailbox push and mid-pulse -> mbox_valid=0, count=0, core_reset=1, CTRL reads 0x1 afterwards.
